boltzmann_sample_accumulator: RTL and testbench

Downstream statistics stage for the Boltzmann node array: consumes the registered `node` bits of NUM_NODES Boltzmann nodes once per Gibbs sweep. It discards a programmable burn-in, then counts a programmable number of samples, accumulating:

- per-node activation counts;
- pairwise co-activation counts for ring neighbours (i, i+1 mod NUM_NODES).

These are the data statistics the future `train` path consumes. Results are read back through a registered address/data port.

---
 rtl/boltzmann_sample_accumulator_if.sv | 30 +++
 rtl/boltzmann_sample_accumulator.sv | 148 ++++++++++++++
 tb/tb_boltzmann_sample_accumulator.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boltzmann_sample_accumulator_if.sv
// Bus bundle for the Boltzmann sample accumulator: run control, sweep input,
// read-back port and status outputs. The master side drives the run.
interface boltzmann_sample_accumulator_if #(
    parameter int NUM_NODES   = 8,
    parameter int COUNT_WIDTH = 16
);
    localparam int ADDR_W = $clog2(2 * NUM_NODES) + 1;

    logic                   start;
    logic                   abort;
    logic [COUNT_WIDTH-1:0] burn_in;
    logic [COUNT_WIDTH-1:0] num_samples;
    logic                   node_valid;
    logic [NUM_NODES-1:0]   nodes;
    logic [ADDR_W-1:0]      rd_addr;
    logic [COUNT_WIDTH-1:0] rd_data;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] samples_taken;

    modport master (
        output start, abort, burn_in, num_samples, node_valid, nodes, rd_addr,
        input  rd_data, busy, done, samples_taken
    );

    modport slave (
        input  start, abort, burn_in, num_samples, node_valid, nodes, rd_addr,
        output rd_data, busy, done, samples_taken
    );
endinterface

// File: rtl/boltzmann_sample_accumulator.sv
// Statistics stage behind the Boltzmann node array. Skips a programmable
// burn-in, then accumulates per-node activation counts and ring-neighbour
// co-activation counts over a programmable number of sweeps. All counters
// saturate. Counts are read back through a registered address/data port.
module boltzmann_sample_accumulator #(
    parameter int NUM_NODES   = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            on,
    boltzmann_sample_accumulator_if.slave   bus
);
    localparam int ADDR_W = $clog2(2 * NUM_NODES) + 1;
    localparam int IDX_W  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURN, S_COLLECT, S_DONE} state_t;
    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    state_t state_q, state_d;
    cnt_t   burn_cnt_q, burn_cnt_d;
    cnt_t   burn_lim_q, burn_lim_d;
    cnt_t   num_lim_q,  num_lim_d;
    cnt_t   samp_q,     samp_d;
    cnt_t   node_cnt_q [NUM_NODES];
    cnt_t   node_cnt_d [NUM_NODES];
    cnt_t   pair_cnt_q [NUM_NODES];
    cnt_t   pair_cnt_d [NUM_NODES];
    cnt_t   rd_data_q,  rd_data_d;
    logic   busy_q,     busy_d;
    logic   done_q,     done_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        if (v == '1) begin
            return v;
        end
        return v + cnt_t'(1);
    endfunction

    // Run sequencing and counter updates. Start clears and latches the run
    // parameters; abort drops to IDLE leaving counts in place.
    always_comb begin
        state_d    = state_q;
        burn_cnt_d = burn_cnt_q;
        burn_lim_d = burn_lim_q;
        num_lim_d  = num_lim_q;
        samp_d     = samp_q;
        node_cnt_d = node_cnt_q;
        pair_cnt_d = pair_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = (bus.burn_in != '0) ? S_BURN : S_COLLECT;
                    burn_lim_d = bus.burn_in;
                    num_lim_d  = bus.num_samples;
                    burn_cnt_d = '0;
                    samp_d     = '0;
                    for (int i = 0; i < NUM_NODES; i++) begin
                        node_cnt_d[i] = '0;
                        pair_cnt_d[i] = '0;
                    end
                end
            end
            S_BURN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.node_valid) begin
                    burn_cnt_d = sat_inc(burn_cnt_q);
                    if (sat_inc(burn_cnt_q) == burn_lim_q) begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (samp_q >= num_lim_q) begin
                    // Only reachable with a zero sample budget.
                    state_d = S_DONE;
                end else if (bus.node_valid) begin
                    samp_d = sat_inc(samp_q);
                    for (int i = 0; i < NUM_NODES; i++) begin
                        if (bus.nodes[i]) begin
                            node_cnt_d[i] = sat_inc(node_cnt_q[i]);
                        end
                        if (bus.nodes[i] && bus.nodes[(i + 1) % NUM_NODES]) begin
                            pair_cnt_d[i] = sat_inc(pair_cnt_q[i]);
                        end
                    end
                    if (sat_inc(samp_q) == num_lim_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_BURN) || (state_d == S_COLLECT);
        done_d = (state_d == S_DONE);
    end

    // Read mux on the current (pre-update) counts; out-of-range returns 0.
    always_comb begin
        rd_data_d = '0;
        if (bus.rd_addr < ADDR_W'(NUM_NODES)) begin
            rd_data_d = node_cnt_q[IDX_W'(bus.rd_addr)];
        end else if (bus.rd_addr < ADDR_W'(2 * NUM_NODES)) begin
            rd_data_d = pair_cnt_q[IDX_W'(bus.rd_addr - ADDR_W'(NUM_NODES))];
        end
    end

    // State, counters and registered outputs; reset wipes every count.
    always_ff @(posedge clk or negedge on) begin
        if (!on) begin
            state_q    <= S_IDLE;
            burn_cnt_q <= '0;
            burn_lim_q <= '0;
            num_lim_q  <= '0;
            samp_q     <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                node_cnt_q[i] <= '0;
                pair_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            burn_cnt_q <= burn_cnt_d;
            burn_lim_q <= burn_lim_d;
            num_lim_q  <= num_lim_d;
            samp_q     <= samp_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            for (int i = 0; i < NUM_NODES; i++) begin
                node_cnt_q[i] <= node_cnt_d[i];
                pair_cnt_q[i] <= pair_cnt_d[i];
            end
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.samples_taken = samp_q;
endmodule

// File: tb/tb_boltzmann_sample_accumulator.sv
// Bench for boltzmann_sample_accumulator: a 16-bit instance for the main
// scenarios and a 4-bit instance for saturation and mid-run reset.
module tb_boltzmann_sample_accumulator;
    logic clk = 1'b0;
    logic on8 = 1'b0;
    logic on4 = 1'b0;

    always #5 clk = ~clk;

    boltzmann_sample_accumulator_if #(.NUM_NODES(8), .COUNT_WIDTH(16)) if8 ();
    boltzmann_sample_accumulator_if #(.NUM_NODES(8), .COUNT_WIDTH(4))  if4 ();

    boltzmann_sample_accumulator #(.NUM_NODES(8), .COUNT_WIDTH(16)) dut8 (
        .clk(clk), .on(on8), .bus(if8.slave)
    );
    boltzmann_sample_accumulator #(.NUM_NODES(8), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .on(on4), .bus(if4.slave)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0]  sweeps[$];
    int          exp_node[8];
    int          exp_pair[8];
    int          exp_samp;
    logic [15:0] got[16];

    // Reference: sweep j is counted when burn <= j < burn+num.
    task automatic model(input int burn, input int num, input int maxv);
        exp_samp = 0;
        for (int i = 0; i < 8; i++) begin
            exp_node[i] = 0;
            exp_pair[i] = 0;
        end
        for (int j = 0; j < sweeps.size(); j++) begin
            if (j >= burn && j < burn + num) begin
                exp_samp++;
                for (int i = 0; i < 8; i++) begin
                    if (sweeps[j][i]) exp_node[i]++;
                    if (sweeps[j][i] && sweeps[j][(i + 1) % 8]) exp_pair[i]++;
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (exp_node[i] > maxv) exp_node[i] = maxv;
            if (exp_pair[i] > maxv) exp_pair[i] = maxv;
        end
    endtask

    // All helpers start and end just after a falling edge.
    task automatic do_start(input int b, input int n, input bit with_valid);
        if8.start       = 1'b1;
        if8.burn_in     = 16'(b);
        if8.num_samples = 16'(n);
        if8.node_valid  = with_valid;
        if8.nodes       = 8'hFF;
        @(negedge clk);
        if8.start      = 1'b0;
        if8.node_valid = 1'b0;
        sweeps.delete();
    endtask

    task automatic send(input logic [7:0] v);
        if8.node_valid = 1'b1;
        if8.nodes      = v;
        sweeps.push_back(v);
        @(negedge clk);
        if8.node_valid = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            if8.rd_addr = 5'(a);
            @(negedge clk);
            got[a] = if8.rd_data;
        end
    endtask

    task automatic test_reset();
        on8 = 1'b0;
        on4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.rd_data !== 16'd0 || if8.samples_taken !== 16'd0)
            $display("FAIL reset_outputs: busy=%b done=%b rd=%0d st=%0d required 0", if8.busy, if8.done, if8.rd_data, if8.samples_taken);
        else passed++;
        on8 = 1'b1;
        on4 = 1'b1;
        @(negedge clk);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'd0) $display("FAIL reset_read[%0d]: got %0d required 0", a, got[a]);
            else passed++;
        end
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if4.busy !== 1'b0 || if4.done !== 1'b0)
            $display("FAIL idle_status: busy=%b done=%b required 0 0", if8.busy, if8.done);
        else passed++;
    endtask

    task automatic test_basic();
        // Valid in the start cycle must not count toward burn-in.
        do_start(2, 4, 1'b1);
        checks++;
        if (if8.busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", if8.busy);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            send(8'b0000_0011);
            if (k == 4) begin
                checks++;
                if (if8.done !== 1'b0) $display("FAIL basic_early_done: got %b required 0", if8.done);
                else passed++;
            end
        end
        checks++;
        if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.samples_taken !== 16'd4)
            $display("FAIL basic_done: done=%b busy=%b st=%0d required 1 0 4", if8.done, if8.busy, if8.samples_taken);
        else passed++;
        model(2, 4, 65535);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'(a < 8 ? exp_node[a] : exp_pair[a - 8]))
                $display("FAIL basic_cnt[%0d]: got %0d required %0d", a, got[a], (a < 8 ? exp_node[a] : exp_pair[a - 8]));
            else passed++;
        end
        if8.rd_addr = 5'd16;
        @(negedge clk);
        checks++;
        if (if8.rd_data !== 16'd0) $display("FAIL basic_oob16: got %0d required 0", if8.rd_data);
        else passed++;
        if8.rd_addr = 5'd31;
        @(negedge clk);
        checks++;
        if (if8.rd_data !== 16'd0) $display("FAIL basic_oob31: got %0d required 0", if8.rd_data);
        else passed++;
    endtask

    task automatic test_ring();
        do_start(0, 3, 1'b0);
        repeat (3) send(8'b1000_0001);
        checks++;
        if (if8.done !== 1'b1 || if8.samples_taken !== 16'd3)
            $display("FAIL ring_done: done=%b st=%0d required 1 3", if8.done, if8.samples_taken);
        else passed++;
        model(0, 3, 65535);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'(a < 8 ? exp_node[a] : exp_pair[a - 8]))
                $display("FAIL ring_cnt[%0d]: got %0d required %0d", a, got[a], (a < 8 ? exp_node[a] : exp_pair[a - 8]));
            else passed++;
        end
    endtask

    task automatic test_zero_restart();
        int cyc;
        do_start(0, 0, 1'b0);
        checks++;
        if (if8.busy !== 1'b1) $display("FAIL zero_busy: got %b required 1", if8.busy);
        else passed++;
        send(8'hFF);
        checks++;
        if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.samples_taken !== 16'd0)
            $display("FAIL zero_done: done=%b busy=%b st=%0d required 1 0 0", if8.done, if8.busy, if8.samples_taken);
        else passed++;
        model(0, 0, 65535);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'd0) $display("FAIL zero_cnt[%0d]: got %0d required 0", a, got[a]);
            else passed++;
        end
        do_start(1, 2, 1'b0);
        checks++;
        if (if8.busy !== 1'b1 || if8.done !== 1'b0)
            $display("FAIL restart_status: busy=%b done=%b required 1 0", if8.busy, if8.done);
        else passed++;
        cyc = 0;
        while (if8.done !== 1'b1 && cyc < 20) begin
            send(8'($urandom));
            cyc++;
        end
        checks++;
        if (if8.done !== 1'b1 || sweeps.size() != 3)
            $display("FAIL restart_done: done=%b sweeps=%0d required 1 3", if8.done, sweeps.size());
        else passed++;
        model(1, 2, 65535);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'(a < 8 ? exp_node[a] : exp_pair[a - 8]))
                $display("FAIL restart_cnt[%0d]: got %0d required %0d", a, got[a], (a < 8 ? exp_node[a] : exp_pair[a - 8]));
            else passed++;
        end
    endtask

    task automatic test_abort();
        do_start(0, 5, 1'b0);
        send(8'($urandom));
        send(8'($urandom));
        if8.start       = 1'b1;
        if8.burn_in     = 16'd0;
        if8.num_samples = 16'd1;
        @(negedge clk);
        if8.start = 1'b0;
        checks++;
        if (if8.busy !== 1'b1 || if8.samples_taken !== 16'd2)
            $display("FAIL ignored_start: busy=%b st=%0d required 1 2", if8.busy, if8.samples_taken);
        else passed++;
        if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.samples_taken !== 16'd2)
            $display("FAIL abort_status: busy=%b done=%b st=%0d required 0 0 2", if8.busy, if8.done, if8.samples_taken);
        else passed++;
        // Valid while idle must be ignored.
        if8.node_valid = 1'b1;
        if8.nodes      = 8'hFF;
        @(negedge clk);
        if8.node_valid = 1'b0;
        model(0, 5, 65535);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (got[a] !== 16'(a < 8 ? exp_node[a] : exp_pair[a - 8]))
                $display("FAIL abort_cnt[%0d]: got %0d required %0d", a, got[a], (a < 8 ? exp_node[a] : exp_pair[a - 8]));
            else passed++;
        end
        checks++;
        if (if8.samples_taken !== 16'd2) $display("FAIL abort_hold: st=%0d required 2", if8.samples_taken);
        else passed++;
        do_start(0, 5, 1'b0);
        send(8'($urandom));
        if8.abort = 1'b1;
        if8.start = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        if8.start = 1'b0;
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.samples_taken !== 16'd1)
            $display("FAIL abort_wins: busy=%b done=%b st=%0d required 0 0 1", if8.busy, if8.done, if8.samples_taken);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int b, n, sent, cyc, cnt_now, old;
        logic v;
        logic [7:0] nv;
        for (int it = 0; it < 4; it++) begin
            b = $urandom_range(0, 4);
            n = $urandom_range(1, 10);
            sent = 0;
            cyc = 0;
            cnt_now = 0;
            do_start(b, n, 1'b0);
            if8.rd_addr = 5'd0;
            @(negedge clk);
            while (sent < b + n && cyc < 200) begin
                v  = (it % 2 == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
                nv = 8'($urandom);
                old = cnt_now;
                if8.node_valid = v;
                if8.nodes      = nv;
                if (v) begin
                    if (sent >= b && nv[0]) cnt_now++;
                    sweeps.push_back(nv);
                    sent++;
                end
                @(negedge clk);
                cyc++;
                checks++;
                if (if8.rd_data !== 16'(old))
                    $display("FAIL b2b_rd_latency it%0d cyc%0d: got %0d required %0d", it, cyc, if8.rd_data, old);
                else passed++;
            end
            if8.node_valid = 1'b0;
            checks++;
            if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.samples_taken !== 16'(n) || sent != b + n)
                $display("FAIL b2b_done it%0d: done=%b busy=%b st=%0d required 1 0 %0d", it, if8.done, if8.busy, if8.samples_taken, n);
            else passed++;
            @(negedge clk);
            checks++;
            if (if8.rd_data !== 16'(cnt_now))
                $display("FAIL b2b_rd_final it%0d: got %0d required %0d", it, if8.rd_data, cnt_now);
            else passed++;
            model(b, n, 65535);
            read_all();
            for (int a = 0; a < 16; a++) begin
                checks++;
                if (got[a] !== 16'(a < 8 ? exp_node[a] : exp_pair[a - 8]))
                    $display("FAIL b2b_cnt it%0d [%0d]: got %0d required %0d", it, a, got[a], (a < 8 ? exp_node[a] : exp_pair[a - 8]));
                else passed++;
            end
        end
    endtask

    task automatic test_saturation_reset();
        if4.start       = 1'b1;
        if4.burn_in     = 4'd0;
        if4.num_samples = 4'd15;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (15) begin
            if4.node_valid = 1'b1;
            if4.nodes      = 8'hFF;
            @(negedge clk);
        end
        if4.node_valid = 1'b0;
        checks++;
        if (if4.done !== 1'b1 || if4.samples_taken !== 4'd15)
            $display("FAIL sat_done: done=%b st=%0d required 1 15", if4.done, if4.samples_taken);
        else passed++;
        for (int a = 0; a < 16; a++) begin
            if4.rd_addr = 5'(a);
            @(negedge clk);
            checks++;
            if (if4.rd_data !== 4'd15) $display("FAIL sat_cnt[%0d]: got %0d required 15", a, if4.rd_data);
            else passed++;
        end
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if4.rd_addr = 5'd0;
        repeat (5) begin
            if4.node_valid = 1'b1;
            @(negedge clk);
        end
        on4 = 1'b0;
        #1;
        checks++;
        if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.samples_taken !== 4'd0 || if4.rd_data !== 4'd0)
            $display("FAIL async_reset: busy=%b done=%b st=%0d rd=%0d required 0 0 0 0", if4.busy, if4.done, if4.samples_taken, if4.rd_data);
        else passed++;
        @(negedge clk);
        if4.node_valid = 1'b0;
        on4 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            if4.rd_addr = 5'(a);
            @(negedge clk);
            checks++;
            if (if4.rd_data !== 4'd0) $display("FAIL reset_clear[%0d]: got %0d required 0", a, if4.rd_data);
            else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if8.start = 1'b0; if8.abort = 1'b0; if8.burn_in = '0; if8.num_samples = '0;
        if8.node_valid = 1'b0; if8.nodes = '0; if8.rd_addr = '0;
        if4.start = 1'b0; if4.abort = 1'b0; if4.burn_in = '0; if4.num_samples = '0;
        if4.node_valid = 1'b0; if4.nodes = '0; if4.rd_addr = '0;
        test_reset();
        test_basic();
        test_ring();
        test_zero_restart();
        test_abort();
        test_back_to_back();
        test_saturation_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
